icache_dm: RTL and testbench
============================

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch port and external instruction memory.
- The CPU presents a fetch address and a request-valid bit and expects the instruction on the same cycle.
- On a hit the cache returns the word combinationally.
- On a miss it asserts a stall, refills the whole line from memory one word at a time with a req/ack handshake, then serves the fetch.

Parameters:
- LINES, 16: number of cache lines. Power of two, at least 2.
- WORDS, 4: 32-bit words per line. Power of two, at least 2.
- Derived widths:
  - OFF = log2(WORDS)
  - IDX = log2(LINES)
  - TAG = 30 - OFF - IDX

Ports:
- CLK, in, 1: global clock, rising edge.
- RESET, in, 1: synchronous, active-high reset.
- i_addr, in, 32: fetch address from the CPU PC. Bits [1:0] are ignored.
- i_req, in, 1: fetch request valid.
- i_data, out, 32: instruction returned to the CPU.
- i_stall, out, 1: high means i_data is not valid. The CPU must hold PC and IF/ID.
- flush, in, 1: invalidate all lines.
- mem_addr, out, 32: word-aligned external memory read address.
- mem_req, out, 1: memory read request.
- mem_rdata, in, 32: memory read data, valid when mem_ack = 1.
- mem_ack, in, 1: one-cycle acknowledge for the current mem_addr.
- hit_cnt, out, 32: accepted hits, saturating at 32'hFFFF_FFFF.
- miss_cnt, out, 32: misses started, saturating at 32'hFFFF_FFFF.

Behaviour:
- Storage:
  - data array LINES x WORDS x 32.
  - tag array LINES x TAG.
  - valid bit per line.
- Address split:
  - tag = i_addr[31:IDX+OFF+2]
  - index = i_addr[IDX+OFF+1:OFF+2]
  - offset = i_addr[OFF+1:2]
- Hit definition: hit = valid[index] & (tag_array[index] == tag), evaluated combinationally.
- FSM states are IDLE, REFILL and DONE.
- IDLE:
  - If i_req = 0: i_stall = 0, i_data = 0, and no counters change.
  - If i_req = 1 and hit: i_data = data[index][offset] in the same cycle, i_stall = 0, and hit_cnt increments.
  - If i_req = 1 and miss:
    - i_stall = 1 combinationally.
    - Capture miss_tag and miss_index.
    - word counter = 0, miss_cnt increments.
    - Next state is REFILL.
- REFILL:
  - i_stall = 1 and mem_req = 1.
  - mem_addr = {miss_tag, miss_index, wcnt, 2'b00}, stable until ack.
  - On mem_ack, write mem_rdata into data[miss_index][wcnt] and increment wcnt.
  - If wcnt == WORDS-1 at ack:
    - Write tag[miss_index] = miss_tag.
    - Set valid[miss_index] = 1, unless a flush is pending.
    - Next state is DONE.
  - mem_req stays high between words. Each new address appears the cycle after the ack.
  - i_addr and i_req are ignored. The CPU is required to hold them while stalled.
- DONE:
  - i_stall = 1 and mem_req = 0.
  - Return to IDLE next cycle, where the held fetch hits.
  - Miss penalty is 2 + sum of per-word handshake cycles.
  - If a pending flush suppressed the valid bit, the re-fetch misses again. This is intentional.
- Flush:
  - In IDLE or DONE: all valid bits clear at the clock edge.
  - flush and i_req in the same IDLE cycle: lookup uses the pre-flush valids, and the flush applies at the edge.
  - During REFILL: set flush_pend. Clear all valids at the final ack, without setting the filled line valid. flush_pend clears on entering DONE.
- Counters: hit_cnt and miss_cnt saturate and never wrap.
- Reset (synchronous):
  - state = IDLE, all valid = 0, wcnt = 0, flush_pend = 0.
  - mem_req = 0, mem_addr = 0, hit_cnt = 0, miss_cnt = 0.
  - Combinational outputs after reset: i_stall = i_req (cold miss), i_data = 0.
  - Data and tag arrays are not reset.
  - RESET during REFILL abandons the refill. Any late mem_ack is ignored, and the line stays invalid.
- Unexpected acks: mem_ack in IDLE or DONE is ignored.

Test Plan:
- Cold miss: RESET, then i_req = 1, i_addr = 32'h0000_0040, memory returns 32'hA0..A3 with 1-cycle acks.
  - mem_addr must be 40, 44, 48, 4C.
  - i_stall must be high for 6 cycles, then i_data = 32'hA0 with i_stall = 0.
  - miss_cnt = 1.
- Line hits: after the cold miss, fetch 44, 48, 4C on consecutive cycles.
  - i_data must be A1, A2, A3 with i_stall = 0.
  - hit_cnt = 4, counting the replayed 40.
- Conflict: fetch 32'h0000_0440, which has the same index as 40 with a different tag.
  - Must miss and refill 440 to 44C.
  - A subsequent fetch of 40 must miss again.
  - miss_cnt = 3.
- Slow memory: 3-cycle ack latency per word.
  - mem_addr stays stable until each ack.
  - Total stall is 2 + 4×3 = 14 cycles.
  - No data is written without an ack.
- Flush mid-refill: pulse flush while wcnt = 1.
  - The refill completes and DONE is reached.
  - The replayed fetch misses again and a second refill starts.
  - Afterwards valid[index] = 1.
- Reset mid-refill: assert RESET after 2 acks.
  - mem_req = 0 next cycle.
  - A late mem_ack is ignored.
  - Re-fetching the same address misses and refills all 4 words from word 0.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache.
// Hits are served combinationally in IDLE. A miss stalls the CPU and refills the
// whole line word by word over a req/ack memory handshake (REFILL). One DONE
// cycle follows, after which the held fetch is replayed and hits.
module icache_dm #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] i_addr,
  input  logic        i_req,
  output logic [31:0] i_data,
  output logic        i_stall,
  input  logic        flush,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF = $clog2(WORDS);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 30 - OFF - IDX;
  localparam logic [OFF-1:0] WLAST = OFF'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Storage; the data and tag arrays are deliberately left without reset.
  logic [31:0]    r_data [LINES][WORDS];
  logic [TAG-1:0] r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  logic [TAG-1:0] r_miss_tag;
  logic [IDX-1:0] r_miss_index;
  logic [OFF-1:0] r_wcnt;
  logic           r_flush_pend;
  logic [31:0]    r_hit_cnt;
  logic [31:0]    r_miss_cnt;

  logic [TAG-1:0] w_tag;
  logic [IDX-1:0] w_index;
  logic [OFF-1:0] w_offset;
  logic           w_hit;
  logic           w_hit_acc;
  logic           w_miss_start;
  logic           w_fill_we;
  logic           w_fill_last;
  logic           w_unused;

  assign w_tag    = i_addr[31:IDX+OFF+2];
  assign w_index  = i_addr[IDX+OFF+1:OFF+2];
  assign w_offset = i_addr[OFF+1:2];
  assign w_hit    = r_valid[w_index] & (r_tag[w_index] == w_tag);
  // Byte offset within a word is not used by a word-wide fetch port.
  assign w_unused = ^i_addr[1:0];

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, CPU/memory outputs and update strobes.
  always_comb begin
    w_state_nxt  = r_state;
    i_stall      = 1'b0;
    i_data       = '0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    w_hit_acc    = 1'b0;
    w_miss_start = 1'b0;
    w_fill_we    = 1'b0;
    w_fill_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          if (w_hit) begin
            i_data    = r_data[w_index][w_offset];
            w_hit_acc = 1'b1;
          end else begin
            i_stall      = 1'b1;
            w_miss_start = 1'b1;
            w_state_nxt  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        i_stall  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {r_miss_tag, r_miss_index, r_wcnt, 2'b00};
        if (mem_ack) begin
          w_fill_we = 1'b1;
          if (r_wcnt == WLAST) begin
            w_fill_last = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        i_stall     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Miss bookkeeping, valid bits, deferred flush and saturating counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid      <= '0;
      r_wcnt       <= '0;
      r_flush_pend <= 1'b0;
      r_miss_tag   <= '0;
      r_miss_index <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_miss_start) begin
        r_miss_tag   <= w_tag;
        r_miss_index <= w_index;
        r_wcnt       <= '0;
      end else if (w_fill_we) begin
        r_wcnt <= r_wcnt + OFF'(1);
      end

      // A flush seen during the refill (now or earlier) wins over marking the
      // freshly filled line valid; outside REFILL a flush applies immediately.
      if (w_fill_last) begin
        if (r_flush_pend | flush) begin
          r_valid <= '0;
        end else begin
          r_valid[r_miss_index] <= 1'b1;
        end
      end else if (flush && (r_state != S_REFILL)) begin
        r_valid <= '0;
      end

      if ((r_state == S_REFILL) && !w_fill_last) begin
        if (flush) begin
          r_flush_pend <= 1'b1;
        end
      end else begin
        r_flush_pend <= 1'b0;
      end

      if (w_hit_acc && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_start && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  // Line fill: data word per ack, tag on the final word.
  always_ff @(posedge CLK) begin
    if (w_fill_we && !RESET) begin
      r_data[r_miss_index][r_wcnt] <= mem_rdata;
    end
    if (w_fill_last && !RESET) begin
      r_tag[r_miss_index] <= r_miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed testbench for icache_dm (default LINES=16, WORDS=4).
module tb_icache_dm;

  logic        CLK;
  logic        RESET;
  logic [31:0] i_addr;
  logic        i_req;
  logic [31:0] i_data;
  logic        i_stall;
  logic        flush;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks;
  int errors;

  // Results of the most recent fetch.
  int          f_stalls;
  int          f_acks;
  int          f_bad;
  logic [31:0] f_data;
  logic        f_stall_s;
  logic [31:0] f_log [16];

  icache_dm #(.LINES(16), .WORDS(4)) dut (
    .CLK(CLK), .RESET(RESET), .i_addr(i_addr), .i_req(i_req),
    .i_data(i_data), .i_stall(i_stall), .flush(flush),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // External memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h4) return 32'hA0 + {30'd0, a[3:2]};
    return a ^ 32'h5A5A_0000;
  endfunction

  // Present a fetch and play the memory until the CPU is released.
  // flush_at: pulse flush in the REFILL cycle after that many acks (-1 none).
  // rst_at: assert RESET in the REFILL cycle after that many acks (-1 none).
  task automatic run_fetch(input logic [31:0] addr, input int lat,
                           input int flush_at, input int rst_at);
    int waitc;
    bit flushed;
    logic [31:0] base;
    base = {addr[31:4], 4'h0};
    f_stalls = 0; f_acks = 0; f_bad = 0; f_data = '0;
    waitc = 0; flushed = 0;
    @(negedge CLK);
    i_req = 1'b1; i_addr = addr; flush = 1'b0; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (!i_stall) begin
        f_data = i_data;
        return;
      end
      if (rst_at >= 0 && f_acks == rst_at && mem_req) begin
        RESET = 1'b1;
        return;
      end
      f_stalls++;
      if (mem_req) begin
        if (mem_addr !== base + 32'(4 * (f_acks % 4))) f_bad++;
        if (flush_at >= 0 && !flushed && f_acks == flush_at) begin
          flush = 1'b1;
          flushed = 1;
        end
        waitc++;
        if (waitc >= lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_addr);
          if (f_acks < 16) f_log[f_acks] = mem_addr;
          f_acks++;
          waitc = 0;
        end
      end
      @(negedge CLK);
      mem_ack = 1'b0;
      flush = 1'b0;
    end
    checks++; errors++;
    $display("FAIL fetch_timeout addr=%h stalls=%0d acks=%0d, required release within 200 cycles",
             addr, f_stalls, f_acks);
  endtask

  // Single-cycle fetch, sampling the combinational response.
  task automatic drive_fetch(input logic [31:0] addr, input logic fl);
    @(negedge CLK);
    i_req = 1'b1; i_addr = addr; flush = fl; mem_ack = 1'b0;
    #1;
    f_stall_s = i_stall;
    f_data = i_data;
  endtask

  task automatic test_reset();
    RESET = 1'b1; i_req = 1'b0; i_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (i_stall !== 1'b0 || i_data !== 32'h0) begin
      errors++; $display("FAIL reset_idle_out stall=%b data=%h, required 0/0", i_stall, i_data);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_mem req=%b addr=%h, required 0/0", mem_req, mem_addr);
    end
    checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_cnt hit=%0d miss=%0d, required 0/0", hit_cnt, miss_cnt);
    end
    i_req = 1'b1; i_addr = 32'h40;
    #1;
    checks++;
    if (i_stall !== 1'b1 || i_data !== 32'h0) begin
      errors++; $display("FAIL reset_cold_stall stall=%b data=%h, required 1/0", i_stall, i_data);
    end
    @(negedge CLK);
    RESET = 1'b0; i_req = 1'b0;
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h40, 1, -1, -1);
    checks++;
    if (f_stalls != 6) begin
      errors++; $display("FAIL cold_stall_cycles got %0d, required 6", f_stalls);
    end
    checks++;
    if (f_acks != 4 || f_bad != 0) begin
      errors++; $display("FAIL cold_acks acks=%0d bad_addr=%0d, required 4/0", f_acks, f_bad);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (f_log[i] !== 32'h40 + 32'(4 * i)) begin
        errors++; $display("FAIL cold_addr%0d got %h, required %h", i, f_log[i], 32'h40 + 32'(4 * i));
      end
    end
    checks++;
    if (f_data !== 32'hA0) begin
      errors++; $display("FAIL cold_data got %h, required 000000a0", f_data);
    end
    checks++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin
      errors++; $display("FAIL cold_cnt hit=%0d miss=%0d, required 0/1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_line_hits();
    for (int i = 1; i < 4; i++) begin
      drive_fetch(32'h40 + 32'(4 * i), 1'b0);
      checks++;
      if (f_stall_s !== 1'b0 || f_data !== 32'hA0 + 32'(i)) begin
        errors++; $display("FAIL hit_word%0d stall=%b data=%h, required 0/%h", i, f_stall_s, f_data, 32'hA0 + 32'(i));
      end
    end
    @(negedge CLK);
    i_req = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 32'd4 || i_data !== 32'h0 || i_stall !== 1'b0) begin
      errors++; $display("FAIL hit_cnt hit=%0d data=%h stall=%b, required 4/0/0", hit_cnt, i_data, i_stall);
    end
  endtask

  task automatic test_conflict();
    run_fetch(32'h440, 1, -1, -1);
    checks++;
    if (f_stalls != 6 || f_log[0] !== 32'h440 || f_log[3] !== 32'h44C) begin
      errors++; $display("FAIL conflict_refill stalls=%0d first=%h last=%h, required 6/440/44c", f_stalls, f_log[0], f_log[3]);
    end
    checks++;
    if (f_data !== 32'h5A5A_0440) begin
      errors++; $display("FAIL conflict_data got %h, required 5a5a0440", f_data);
    end
    run_fetch(32'h40, 1, -1, -1);
    checks++;
    if (f_stalls != 6 || f_data !== 32'hA0) begin
      errors++; $display("FAIL conflict_remiss stalls=%0d data=%h, required 6/a0", f_stalls, f_data);
    end
    checks++;
    if (miss_cnt !== 32'd3 || hit_cnt !== 32'd5) begin
      errors++; $display("FAIL conflict_cnt hit=%0d miss=%0d, required 5/3", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_slow_mem();
    run_fetch(32'h100, 3, -1, -1);
    checks++;
    if (f_stalls != 14) begin
      errors++; $display("FAIL slow_stall_cycles got %0d, required 14", f_stalls);
    end
    checks++;
    if (f_bad != 0 || f_acks != 4) begin
      errors++; $display("FAIL slow_addr_stable bad=%0d acks=%0d, required 0/4", f_bad, f_acks);
    end
    checks++;
    if (f_data !== mem_word(32'h100)) begin
      errors++; $display("FAIL slow_data got %h, required %h", f_data, mem_word(32'h100));
    end
    drive_fetch(32'h108, 1'b0);
    checks++;
    if (f_stall_s !== 1'b0 || f_data !== mem_word(32'h108)) begin
      errors++; $display("FAIL slow_hit stall=%b data=%h, required 0/%h", f_stall_s, f_data, mem_word(32'h108));
    end
  endtask

  task automatic test_flush_idle();
    drive_fetch(32'h40, 1'b1);
    checks++;
    if (f_stall_s !== 1'b0 || f_data !== 32'hA0) begin
      errors++; $display("FAIL flush_idle_lookup stall=%b data=%h, required 0/a0", f_stall_s, f_data);
    end
    run_fetch(32'h40, 1, -1, -1);
    checks++;
    if (f_stalls != 6 || f_data !== 32'hA0) begin
      errors++; $display("FAIL flush_idle_remiss stalls=%0d data=%h, required 6/a0", f_stalls, f_data);
    end
  endtask

  task automatic test_flush_refill();
    run_fetch(32'h200, 1, 1, -1);
    checks++;
    if (f_stalls != 12 || f_acks != 8 || f_bad != 0) begin
      errors++; $display("FAIL flush_refill_twice stalls=%0d acks=%0d bad=%0d, required 12/8/0", f_stalls, f_acks, f_bad);
    end
    checks++;
    if (f_data !== mem_word(32'h200)) begin
      errors++; $display("FAIL flush_refill_data got %h, required %h", f_data, mem_word(32'h200));
    end
    drive_fetch(32'h20C, 1'b0);
    checks++;
    if (f_stall_s !== 1'b0 || f_data !== mem_word(32'h20C)) begin
      errors++; $display("FAIL flush_refill_valid stall=%b data=%h, required 0/%h", f_stall_s, f_data, mem_word(32'h20C));
    end
  endtask

  task automatic test_reset_refill();
    run_fetch(32'h80, 1, -1, 2);
    @(negedge CLK);
    RESET = 1'b0; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (mem_req !== 1'b0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_refill_abort req=%b hit=%0d miss=%0d, required 0/0/0", mem_req, hit_cnt, miss_cnt);
    end
    @(negedge CLK);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || i_stall !== 1'b0) begin
      errors++; $display("FAIL rst_late_ack req=%b stall=%b, required 0/0", mem_req, i_stall);
    end
    run_fetch(32'h80, 1, -1, -1);
    checks++;
    if (f_stalls != 6 || f_acks != 4 || f_log[0] !== 32'h80) begin
      errors++; $display("FAIL rst_refetch stalls=%0d acks=%0d first=%h, required 6/4/80", f_stalls, f_acks, f_log[0]);
    end
    checks++;
    if (f_data !== mem_word(32'h80) || miss_cnt !== 32'd1) begin
      errors++; $display("FAIL rst_refetch_data data=%h miss=%0d, required %h/1", f_data, miss_cnt, mem_word(32'h80));
    end
  endtask

  task automatic test_idle_noreq();
    @(negedge CLK);
    i_req = 1'b0; i_addr = 32'h84; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (i_stall !== 1'b0 || i_data !== 32'h0) begin
      errors++; $display("FAIL noreq_out stall=%b data=%h, required 0/0", i_stall, i_data);
    end
    @(negedge CLK);
    mem_ack = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL noreq_cnt hit=%0d miss=%0d req=%b, required 1/1/0", hit_cnt, miss_cnt, mem_req);
    end
    drive_fetch(32'h84, 1'b0);
    checks++;
    if (f_stall_s !== 1'b0 || f_data !== mem_word(32'h84)) begin
      errors++; $display("FAIL noreq_hit stall=%b data=%h, required 0/%h", f_stall_s, f_data, mem_word(32'h84));
    end
    @(negedge CLK);
    i_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_slow_mem();
    test_flush_idle();
    test_flush_refill();
    test_reset_refill();
    test_idle_noreq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
